// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel clock-enable divider and scan enable.
// Define VGA_FRAME_COUNT_EN to build the completed-frame counter; otherwise frame_count is tied to 0.
module vga_timing_gen #(
   parameter int H_ACTIVE   = 800,
   parameter int H_FP       = 56,
   parameter int H_SYNC     = 120,
   parameter int H_BP       = 64,
   parameter int V_ACTIVE   = 600,
   parameter int V_FP       = 37,
   parameter int V_SYNC     = 6,
   parameter int V_BP       = 23,
   parameter int H_SYNC_POL = 1,
   parameter int V_SYNC_POL = 1,
   parameter int CLK_DIV    = 1,
   parameter int COL_W      = 11,
   parameter int ROW_W      = 10,
   parameter int FRAME_W    = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               enable,
   output logic               pix_tick,
   output logic [COL_W-1:0]   display_col,
   output logic [ROW_W-1:0]   display_row,
   output logic               visible,
   output logic               hsync,
   output logic               vsync,
   output logic               line_start,
   output logic               frame_start,
   output logic [FRAME_W-1:0] frame_count
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [COL_W-1:0] COL_LAST  = COL_W'(H_TOTAL - 1);
   localparam logic [COL_W-1:0] COL_ACT   = COL_W'(H_ACTIVE);
   localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(V_TOTAL - 1);
   localparam logic [ROW_W-1:0] ROW_ACT   = ROW_W'(V_ACTIVE);
   // Sync window bounds carry one extra bit so a zero back porch cannot wrap the end bound.
   localparam logic [COL_W:0]   HS_BEGIN  = (COL_W + 1)'(H_ACTIVE + H_FP);
   localparam logic [COL_W:0]   HS_END    = (COL_W + 1)'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [ROW_W:0]   VS_BEGIN  = (ROW_W + 1)'(V_ACTIVE + V_FP);
   localparam logic [ROW_W:0]   VS_END    = (ROW_W + 1)'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic             HS_ON     = 1'(H_SYNC_POL);
   localparam logic             VS_ON     = 1'(V_SYNC_POL);

   logic [DIV_W-1:0] div_cnt_r;
   logic [DIV_W-1:0] div_next_s;
   logic [COL_W-1:0] col_r;
   logic [COL_W-1:0] col_next_s;
   logic [ROW_W-1:0] row_r;
   logic [ROW_W-1:0] row_next_s;
   logic             advance_s;
   logic             vis_next_s;
   logic             hs_next_s;
   logic             vs_next_s;
   logic             sof_s;
   logic             visible_r;
   logic             hsync_r;
   logic             vsync_r;
   logic             pix_tick_r;
   logic             line_start_r;
   logic             frame_start_r;

   // Divider step and the raster position the next advance moves to.
   always_comb begin
      advance_s  = 1'b0;
      div_next_s = div_cnt_r;
      col_next_s = col_r;
      row_next_s = row_r;
      if (enable) begin
         if (div_cnt_r == DIV_LAST) begin
            advance_s  = 1'b1;
            div_next_s = '0;
         end else begin
            div_next_s = div_cnt_r + 1'b1;
         end
      end else begin
         advance_s  = 1'b0;
      end
      if (col_r == COL_LAST) begin
         col_next_s = '0;
         if (row_r == ROW_LAST) begin
            row_next_s = '0;
         end else begin
            row_next_s = row_r + 1'b1;
         end
      end else begin
         col_next_s = col_r + 1'b1;
         row_next_s = row_r;
      end
      vis_next_s = (col_next_s < COL_ACT) && (row_next_s < ROW_ACT);
      hs_next_s  = (({1'b0, col_next_s} >= HS_BEGIN) && ({1'b0, col_next_s} < HS_END)) ? HS_ON : ~HS_ON;
      vs_next_s  = (({1'b0, row_next_s} >= VS_BEGIN) && ({1'b0, row_next_s} < VS_END)) ? VS_ON : ~VS_ON;
      sof_s      = advance_s && (col_next_s == '0) && (row_next_s == '0);
   end

   // Raster state and registered outputs, all loaded together on the advance edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         div_cnt_r     <= '0;
         col_r         <= COL_LAST;
         row_r         <= ROW_LAST;
         visible_r     <= 1'b0;
         hsync_r       <= ~HS_ON;
         vsync_r       <= ~VS_ON;
         pix_tick_r    <= 1'b0;
         line_start_r  <= 1'b0;
         frame_start_r <= 1'b0;
      end else begin
         div_cnt_r     <= div_next_s;
         pix_tick_r    <= advance_s;
         line_start_r  <= advance_s && (col_next_s == '0);
         frame_start_r <= sof_s;
         if (advance_s) begin
            col_r     <= col_next_s;
            row_r     <= row_next_s;
            visible_r <= vis_next_s;
            hsync_r   <= hs_next_s;
            vsync_r   <= vs_next_s;
         end
      end
   end

`ifdef VGA_FRAME_COUNT_EN
   logic [FRAME_W-1:0] frame_cnt_r;

   // Completed-frame counter, bumped on the same edge that raises frame_start.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         frame_cnt_r <= '0;
      end else if (sof_s) begin
         frame_cnt_r <= frame_cnt_r + 1'b1;
      end
   end

   assign frame_count = frame_cnt_r;
`else
   assign frame_count = '0;
`endif

   assign pix_tick    = pix_tick_r;
   assign display_col = col_r;
   assign display_row = row_r;
   assign visible     = visible_r;
   assign hsync       = hsync_r;
   assign vsync       = vsync_r;
   assign line_start  = line_start_r;
   assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: two small-raster instances (CLK_DIV=1 and CLK_DIV=3 with low-active syncs).
// Expectations are queued at stimulus time and checked by per-instance monitors on pix_tick.
module tb_vga_timing_gen;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic en_a  = 1'b0;
   logic en_b  = 1'b0;

   logic       pt_a, vis_a, hs_a, vs_a, ls_a, fs_a;
   logic [3:0] col_a, row_a;
   logic [1:0] fc_a;
   logic       pt_b, vis_b, hs_b, vs_b, ls_b, fs_b;
   logic [3:0] col_b, row_b;
   logic [7:0] fc_b;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int k_a      = 0;
   int k_b      = 0;
   int nb       = 0;

   typedef struct {
      int k; int cyc; int col; int row; int vis; int hs; int vs; int ls; int fs; int fc;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];

   // A: H 4/1/1/1 (total 7), V 3/1/1/1 (total 6), 42 pixels per frame.
   vga_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .H_SYNC_POL(1), .V_SYNC_POL(1), .CLK_DIV(1),
      .COL_W(4), .ROW_W(4), .FRAME_W(2)
   ) dut_a (
      .clock(clock), .reset(reset), .enable(en_a), .pix_tick(pt_a),
      .display_col(col_a), .display_row(row_a), .visible(vis_a),
      .hsync(hs_a), .vsync(vs_a), .line_start(ls_a), .frame_start(fs_a),
      .frame_count(fc_a)
   );

   // B: H 8/2/3/2 (total 15), V 4/1/2/1 (total 8), CLK_DIV=3, active-low syncs.
   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .H_SYNC_POL(0), .V_SYNC_POL(0), .CLK_DIV(3),
      .COL_W(4), .ROW_W(4), .FRAME_W(8)
   ) dut_b (
      .clock(clock), .reset(reset), .enable(en_b), .pix_tick(pt_b),
      .display_col(col_b), .display_row(row_b), .visible(vis_b),
      .hsync(hs_b), .vsync(vs_b), .line_start(ls_b), .frame_start(fs_b),
      .frame_count(fc_b)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic flag(input string name);
      checks++;
      failures++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // k-th pixel after reset, expressed as a flat pixel index.
   function automatic exp_t model(input int k, input int c, input int ha, input int hfp, input int hsw,
                                  input int hbp, input int va, input int vfp, input int vsw, input int vbp,
                                  input int hpol, input int vpol, input int fw);
      exp_t e;
      int ht, vt, line, frame;
      ht    = ha + hfp + hsw + hbp;
      vt    = va + vfp + vsw + vbp;
      line  = k / ht;
      frame = line / vt;
      e.k   = k;
      e.cyc = c;
      e.col = k % ht;
      e.row = line % vt;
      e.vis = (e.col < ha && e.row < va) ? 1 : 0;
      e.hs  = (e.col >= ha + hfp && e.col < ha + hfp + hsw) ? hpol : 1 - hpol;
      e.vs  = (e.row >= va + vfp && e.row < va + vfp + vsw) ? vpol : 1 - vpol;
      e.ls  = (e.col == 0) ? 1 : 0;
      e.fs  = (e.col == 0 && e.row == 0) ? 1 : 0;
`ifdef VGA_FRAME_COUNT_EN
      e.fc  = (frame + 1) % (1 << fw);
`else
      e.fc  = 0;
`endif
      return e;
   endfunction

   task automatic cmp(input string p, input exp_t e, input int col, input int row, input int vis,
                      input int hs, input int vs, input int ls, input int fs, input int fc);
      check({p, "_col"}, col, e.col);
      check({p, "_row"}, row, e.row);
      check({p, "_visible"}, vis, e.vis);
      check({p, "_hsync"}, hs, e.hs);
      check({p, "_vsync"}, vs, e.vs);
      check({p, "_line_start"}, ls, e.ls);
      check({p, "_frame_start"}, fs, e.fs);
      check({p, "_frame_count"}, fc, e.fc);
   endtask

   // Hand-computed points of raster A: {col,row,visible,hsync,vsync,line_start,frame_start}.
   task automatic hand_a(input int k);
      exp_t h;
      h.k = k; h.cyc = 0; h.fc = int'(fc_a);
      case (k)
         0:  begin h.col = 0; h.row = 0; h.vis = 1; h.hs = 0; h.vs = 0; h.ls = 1; h.fs = 1; end
         5:  begin h.col = 5; h.row = 0; h.vis = 0; h.hs = 1; h.vs = 0; h.ls = 0; h.fs = 0; end
         6:  begin h.col = 6; h.row = 0; h.vis = 0; h.hs = 0; h.vs = 0; h.ls = 0; h.fs = 0; end
         7:  begin h.col = 0; h.row = 1; h.vis = 1; h.hs = 0; h.vs = 0; h.ls = 1; h.fs = 0; end
         28: begin h.col = 0; h.row = 4; h.vis = 0; h.hs = 0; h.vs = 1; h.ls = 1; h.fs = 0; end
         41: begin h.col = 6; h.row = 5; h.vis = 0; h.hs = 0; h.vs = 0; h.ls = 0; h.fs = 0; end
         42: begin h.col = 0; h.row = 0; h.vis = 1; h.hs = 0; h.vs = 0; h.ls = 1; h.fs = 1; end
         default: return;
      endcase
      cmp("a_hand", h, int'(col_a), int'(row_a), int'(vis_a), int'(hs_a), int'(vs_a),
          int'(ls_a), int'(fs_a), int'(fc_a));
   endtask

   // Monitor A: pops one expectation per pix_tick and checks timing and outputs.
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (pt_a) begin
            if (qa.size() == 0) begin
               flag("a_unexpected_tick");
            end else begin
               e = qa.pop_front();
               check("a_tick_cycle", cyc, e.cyc);
               cmp("a", e, int'(col_a), int'(row_a), int'(vis_a), int'(hs_a), int'(vs_a),
                   int'(ls_a), int'(fs_a), int'(fc_a));
               hand_a(e.k);
            end
         end else begin
            if (qa.size() > 0 && qa[0].cyc <= cyc) begin
               e = qa.pop_front();
               flag("a_missing_tick");
            end
            check("a_idle_strobes", int'(ls_a | fs_a), 0);
         end
      end
   end

   // Monitor B: same scheme for the divided, low-polarity instance.
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (pt_b) begin
            if (qb.size() == 0) begin
               flag("b_unexpected_tick");
            end else begin
               e = qb.pop_front();
               check("b_tick_cycle", cyc, e.cyc);
               cmp("b", e, int'(col_b), int'(row_b), int'(vis_b), int'(hs_b), int'(vs_b),
                   int'(ls_b), int'(fs_b), int'(fc_b));
            end
         end else begin
            if (qb.size() > 0 && qb[0].cyc <= cyc) begin
               e = qb.pop_front();
               flag("b_missing_tick");
            end
            check("b_idle_strobes", int'(ls_b | fs_b), 0);
         end
      end
   end

   task automatic push_a();
      qa.push_back(model(k_a, cyc + 1, 4, 1, 1, 1, 3, 1, 1, 1, 1, 1, 2));
      k_a++;
   endtask

   task automatic push_b();
      if (nb % 3 == 2) begin
         qb.push_back(model(k_b, cyc + 1, 8, 2, 3, 2, 4, 1, 2, 1, 0, 0, 8));
         k_b++;
      end
      nb++;
   endtask

   task automatic check_reset_state(input string p);
      check({p, "_a_col"}, int'(col_a), 6);
      check({p, "_a_row"}, int'(row_a), 5);
      check({p, "_a_visible"}, int'(vis_a), 0);
      check({p, "_a_hsync"}, int'(hs_a), 0);
      check({p, "_a_vsync"}, int'(vs_a), 0);
      check({p, "_a_pix_tick"}, int'(pt_a), 0);
      check({p, "_a_frame_count"}, int'(fc_a), 0);
      check({p, "_b_col"}, int'(col_b), 14);
      check({p, "_b_row"}, int'(row_b), 7);
      check({p, "_b_hsync"}, int'(hs_b), 1);
      check({p, "_b_vsync"}, int'(vs_b), 1);
      check({p, "_b_frame_count"}, int'(fc_b), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      check_reset_state("reset");
      @(negedge clock);
      reset = 1'b0;
      repeat (2) @(negedge clock);
      check_reset_state("idle_hold");

      // Main run: A pauses for 10 clocks, B has periodic enable gaps.
      for (int i = 0; i < 500; i++) begin
         @(negedge clock);
         en_a = !(i >= 100 && i < 110);
         en_b = (i % 17) < 14;
         if (i == 105) begin
            check("a_pause_col", int'(col_a), (k_a - 1) % 7);
            check("a_pause_row", int'(row_a), ((k_a - 1) / 7) % 6);
         end
         if (en_a) push_a();
         if (en_b) push_b();
      end
      @(negedge clock);
      en_a = 1'b0;
      en_b = 1'b0;
      repeat (3) @(negedge clock);
      check("a_queue_drained", qa.size(), 0);
      check("b_queue_drained", qb.size(), 0);

      for (int j = 0; j < 17; j++) begin
         @(negedge clock);
         en_a = 1'b1;
         push_a();
      end
      @(negedge clock);
      en_a = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      check_reset_state("mid_reset");
      @(negedge clock);
      reset = 1'b0;
      k_a = 0;
      k_b = 0;
      nb  = 0;
      for (int j = 0; j < 9; j++) begin
         @(negedge clock);
         en_a = 1'b1;
         push_a();
      end
      @(negedge clock);
      en_a = 1'b0;
      repeat (3) @(negedge clock);
      check("a_final_drained", qa.size(), 0);
      check("b_final_drained", qb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator that replaces the fixed 800x600 controller. Porch and sync widths, sync polarities and a pixel clock-enable divider are set by parameters. Scanning can be paused with an enable input. It drives the same column/row/visible/sync outputs to the pixel renderer and VGA pins, and adds line/frame start strobes and an optional frame counter for game-tick logic.

## Interface
- H_ACTIVE, 800: visible columns
- H_FP, 56: horizontal front porch (pixels)
- H_SYNC, 120: hsync width (pixels)
- H_BP, 64: horizontal back porch (pixels); H_TOTAL = sum of the four = 1040
- V_ACTIVE, 600: visible rows
- V_FP, 37: vertical front porch (lines)
- V_SYNC, 6: vsync width (lines)
- V_BP, 23: vertical back porch (lines); V_TOTAL = 666
- H_SYNC_POL, 1: active level of hsync (1 = high during sync)
- V_SYNC_POL, 1: active level of vsync
- CLK_DIV, 1: clocks per pixel, ≥1
- COL_W, 11: display_col width; must hold H_TOTAL-1
- ROW_W, 10: display_row width; must hold V_TOTAL-1
- FRAME_W, 8: frame_count width
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- enable  input  1  scan enable; low freezes the raster
- pix_tick  output  1  one-clock strobe at the start of each pixel period
- display_col  output  COL_W  current column, 0..H_TOTAL-1
- display_row  output  ROW_W  current row, 0..V_TOTAL-1
- visible  output  1  col < H_ACTIVE and row < V_ACTIVE
- hsync  output  1  horizontal sync at H_SYNC_POL level
- vsync  output  1  vertical sync at V_SYNC_POL level
- line_start  output  1  one-clock strobe when col becomes 0
- frame_start  output  1  one-clock strobe when (col,row) becomes (0,0)
- frame_count  output  FRAME_W  completed-frame counter (see Configuration)

## Operation
- Divider div_cnt runs 0..CLK_DIV-1 and advances only while enable=1. An internal advance occurs on a clock where enable=1 and div_cnt=CLK_DIV-1. With CLK_DIV=1, every enabled clock is an advance.
- On advance, col increments. At H_TOTAL-1, col wraps to 0 and row increments. At V_TOTAL-1, row wraps to 0.
- All outputs are registered and are updated on the advance edge from the next (col,row). All outputs therefore describe the same pixel in the same cycle, with zero relative skew.
- hsync is active when H_ACTIVE+H_FP ≤ col < H_ACTIVE+H_FP+H_SYNC; otherwise it sits at the inactive level (~H_SYNC_POL).
- vsync is active when V_ACTIVE+V_FP ≤ row < V_ACTIVE+V_FP+V_SYNC. vsync changes only together with a col wrap.
- pix_tick, line_start and frame_start are high for exactly one clock after the advance edge, then return to 0 regardless of enable or CLK_DIV.
- frame_start implies line_start in the same cycle.
- enable=0: div_cnt, col, row, visible, hsync and vsync hold. No strobes are generated. On re-enable, counting resumes from the held div_cnt.
- Reset values: div_cnt=0, col=H_TOTAL-1, row=V_TOTAL-1, visible=0, hsync=~H_SYNC_POL, vsync=~V_SYNC_POL, pix_tick=0, line_start=0, frame_start=0, frame_count=0. The first advance after reset yields (0,0) with frame_start=1.
- Reset asserted mid-frame returns all state to the reset values immediately (asynchronously).

## Timing
- Advance period is CLK_DIV clocks. Line period is H_TOTAL×CLK_DIV clocks. Frame period is H_TOTAL×V_TOTAL×CLK_DIV clocks (692640 with defaults).
- Latency from the advance edge to the outputs is 0 clocks; outputs are valid in the clock following the edge.
- Gating enable low on the clock that would advance suppresses that advance.

## Configuration
- VGA_FRAME_COUNT_EN defined: frame_count increments by 1 on each frame_start edge and wraps modulo 2^FRAME_W. It is held while enable=0 and cleared by reset.
- VGA_FRAME_COUNT_EN undefined: no counter is synthesised and frame_count is tied to 0. All other behaviour is identical.

## Test plan
- Reset with defaults and CLK_DIV=1, then enable=1 → outputs at the reset values. First clock: col=0, row=0, visible=1, frame_start=1, line_start=1.
- Default line → visible for cols 0..799, hsync=1 exactly for cols 856..975, line_start every 1040 clocks.
- Full frame → vsync=1 exactly for rows 637..642, frame_start every 692640 clocks, row wraps 665→0.
- CLK_DIV=3 and H_SYNC_POL=0 → pix_tick one clock every 3 clocks, col changes every 3 clocks, hsync=0 for cols 856..975.
- Drop enable for 10 clocks at col=500 → outputs frozen and no strobes; col=501 on the first advance after re-enable.
- With VGA_FRAME_COUNT_EN, FRAME_W=2, small params (H 4/1/1/1, V 3/1/1/1): frame_count goes 1,2,3,0 over four frames. Assert reset mid-frame → frame_count=0 and col/row back to H_TOTAL-1/V_TOTAL-1 immediately. Without the macro, frame_count stays 0.
